// File: rtl/grad_descent_ctrl.sv
// grad_descent_ctrl
// Iteration sequencer for the 4-D gradient-descent datapath. It owns the Q8.8
// parameter registers, runs the datapath start/done handshake once per
// iteration and applies a saturating update p -= diff. A run stops on
// convergence, on the iteration limit, on a datapath overflow, or on abort.

module grad_descent_ctrl #(
   parameter logic [15:0] MAX_ITER = 16'd256,
   parameter logic [31:0] TOL      = 32'h00000001,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [15:0]      a_init,
   input  logic [15:0]      b_init,
   input  logic [15:0]      c_init,
   input  logic [15:0]      d_init,
   output logic             grad_start,
   input  logic             grad_done,
   input  logic             grad_ovf,
   input  logic [31:0]      value_in,
   input  logic [31:0]      a_diff,
   input  logic [31:0]      b_diff,
   input  logic [31:0]      c_diff,
   input  logic [31:0]      d_diff,
   output logic [15:0]      a_out,
   output logic [15:0]      b_out,
   output logic [15:0]      c_out,
   output logic [15:0]      d_out,
   output logic [31:0]      value_out,
   output logic [CNT_W-1:0] iter_count,
   output logic             busy,
   output logic             done,
   output logic             converged,
   output logic             sat_flag,
   output logic             err_ovf
);

   typedef enum logic [2:0] {IDLE, LOAD, REQ, REL, UPD, CHK, FIN} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

   state_t      state, next_state;
   logic [31:0] a_dq, b_dq, c_dq, d_dq;
   logic [31:0] value_q;
   logic        ovf_q;
   logic        abort_pend;
   logic [16:0] a_upd, b_upd, c_upd, d_upd;
   logic        conv_all;

   // Q8.8 and Q24.8 share the binary point, so the subtraction needs no shift;
   // the 33-bit result is clamped to the 16-bit signed range, bit 16 flags a clamp.
   function automatic logic [16:0] sat_sub(input logic [15:0] p, input logic [31:0] d);
      logic signed [32:0] r;
      r = $signed({{17{p[15]}}, p}) - $signed({d[31], d});
      if (r > 33'sd32767)
         return {1'b1, 16'h7FFF};
      else if (r < -33'sd32768)
         return {1'b1, 16'h8000};
      else
         return {1'b0, r[15:0]};
   endfunction

   // |d| <= TOL; the most negative value has no positive twin and never qualifies.
   function automatic logic within_tol(input logic [31:0] d);
      logic [31:0] mag;
      if (d == 32'h80000000)
         return 1'b0;
      mag = d[31] ? (~d + 32'd1) : d;
      return (mag <= TOL);
   endfunction

   assign busy = (state != IDLE);

   // Candidate parameter updates and convergence test from the captured diffs.
   always_comb begin
      a_upd    = sat_sub(a_out, a_dq);
      b_upd    = sat_sub(b_out, b_dq);
      c_upd    = sat_sub(c_out, c_dq);
      d_upd    = sat_sub(d_out, d_dq);
      conv_all = within_tol(a_dq) & within_tol(b_dq) & within_tol(c_dq) & within_tol(d_dq);
   end

   // State register; reset drops straight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic for the iteration sequence.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = LOAD;
         LOAD: next_state = REQ;
         REQ:  if (grad_done) next_state = REL;
         REL:  if (!grad_done) next_state = ovf_q ? FIN : UPD;
         UPD:  next_state = CHK;
         CHK:  if (conv_all || (iter_count == MAX_CNT) || abort_pend) next_state = FIN;
               else next_state = REQ;
         FIN:  if (!start) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath registers: params, captured datapath results, status and the
   // registered handshake/done strobes derived from the upcoming state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grad_start <= 1'b0;
         done       <= 1'b0;
         a_out      <= '0;
         b_out      <= '0;
         c_out      <= '0;
         d_out      <= '0;
         value_out  <= '0;
         iter_count <= '0;
         converged  <= 1'b0;
         sat_flag   <= 1'b0;
         err_ovf    <= 1'b0;
         a_dq       <= '0;
         b_dq       <= '0;
         c_dq       <= '0;
         d_dq       <= '0;
         value_q    <= '0;
         ovf_q      <= 1'b0;
         abort_pend <= 1'b0;
      end else begin
         grad_start <= (next_state == REQ);
         done       <= (next_state == FIN) && (state != FIN);
         if (busy && abort)
            abort_pend <= 1'b1;
         case (state)
            LOAD: begin
               a_out      <= a_init;
               b_out      <= b_init;
               c_out      <= c_init;
               d_out      <= d_init;
               value_out  <= '0;
               iter_count <= '0;
               converged  <= 1'b0;
               sat_flag   <= 1'b0;
               err_ovf    <= 1'b0;
               abort_pend <= 1'b0;
            end
            REQ: begin
               if (grad_done) begin
                  a_dq    <= a_diff;
                  b_dq    <= b_diff;
                  c_dq    <= c_diff;
                  d_dq    <= d_diff;
                  value_q <= value_in;
                  ovf_q   <= grad_ovf;
               end
            end
            REL: begin
               if (!grad_done && ovf_q)
                  err_ovf <= 1'b1;
            end
            UPD: begin
               a_out      <= a_upd[15:0];
               b_out      <= b_upd[15:0];
               c_out      <= c_upd[15:0];
               d_out      <= d_upd[15:0];
               value_out  <= value_q;
               iter_count <= iter_count + CNT_W'(1);
               if (a_upd[16] | b_upd[16] | c_upd[16] | d_upd[16])
                  sat_flag <= 1'b1;
            end
            CHK: converged <= conv_all;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_grad_descent_ctrl.sv
// tb_grad_descent_ctrl
// Drives runs of the sequencer against a small behavioural datapath, predicts
// each run's final state with a reference model and compares it when done pulses.

module tb_grad_descent_ctrl;

   localparam int          MAXI = 4;
   localparam logic [31:0] TOLV = 32'd2;
   localparam int          LAT  = 2;

   typedef struct packed {
      logic [15:0] a, b, c, d;
      logic [15:0] iter;
      logic        conv, sat, ovf;
      logic [31:0] value;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] a_init = '0, b_init = '0, c_init = '0, d_init = '0;
   logic        grad_start;
   logic        grad_done = 1'b0;
   logic        grad_ovf = 1'b0;
   logic [31:0] value_in = '0;
   logic [31:0] a_diff = '0, b_diff = '0, c_diff = '0, d_diff = '0;
   logic [15:0] a_out, b_out, c_out, d_out;
   logic [31:0] value_out;
   logic [15:0] iter_count;
   logic        busy, done, converged, sat_flag, err_ovf;

   logic [127:0] dif_stim = '0;
   int           ovf_iter = 0;
   int           dps = 0, cnt = 0, hs = 0;
   logic         gs_prev = 1'b0;
   exp_t         q[$];
   int           total = 0;
   int           bad = 0;

   grad_descent_ctrl #(.MAX_ITER(16'd4), .TOL(32'd2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
      .grad_start(grad_start), .grad_done(grad_done), .grad_ovf(grad_ovf),
      .value_in(value_in), .a_diff(a_diff), .b_diff(b_diff), .c_diff(c_diff), .d_diff(d_diff),
      .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
      .value_out(value_out), .iter_count(iter_count), .busy(busy), .done(done),
      .converged(converged), .sat_flag(sat_flag), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model of one complete run with constant diffs per iteration.
   function automatic exp_t model(input logic [63:0] init, input logic [127:0] dif,
                                  input bit abrt, input int ovf_it);
      exp_t e;
      logic [15:0] p[4];
      longint t, dl, mag;
      bit conv;
      e = '0;
      for (int i = 0; i < 4; i++) p[i] = init[16*i +: 16];
      for (int k = 1; k <= MAXI; k++) begin
         if (k == ovf_it) begin
            e.ovf = 1'b1;
            break;
         end
         conv = 1'b1;
         for (int i = 0; i < 4; i++) begin
            dl = longint'($signed(dif[32*i +: 32]));
            t  = longint'($signed(p[i])) - dl;
            if (t > 32767) begin
               p[i] = 16'h7FFF;
               e.sat = 1'b1;
            end else if (t < -32768) begin
               p[i] = 16'h8000;
               e.sat = 1'b1;
            end else begin
               p[i] = t[15:0];
            end
            mag = (dl < 0) ? -dl : dl;
            if (mag > longint'(TOLV)) conv = 1'b0;
         end
         e.iter  = 16'(k);
         e.value = 32'h00001000 + 32'(k);
         if (conv || abrt) begin
            e.conv = conv;
            break;
         end
      end
      e.a = p[0]; e.b = p[1]; e.c = p[2]; e.d = p[3];
      return e;
   endfunction

   // Behavioural datapath: answers each start after LAT cycles, holds done until start drops.
   always @(posedge clk) begin
      if (!rst_n) begin
         dps <= 0; cnt <= 0; hs <= 0;
         grad_done <= 1'b0; grad_ovf <= 1'b0;
      end else begin
         if (!busy) hs <= 0;
         case (dps)
            0: if (grad_start) begin
                  cnt <= LAT; dps <= 1; hs <= hs + 1;
               end
            1: if (cnt == 0) begin
                  grad_done <= 1'b1;
                  grad_ovf  <= (hs == ovf_iter);
                  value_in  <= 32'h00001000 + 32'(hs);
                  a_diff <= dif_stim[31:0];   b_diff <= dif_stim[63:32];
                  c_diff <= dif_stim[95:64];  d_diff <= dif_stim[127:96];
                  dps <= 2;
               end else cnt <= cnt - 1;
            default: if (!grad_start) begin
                  grad_done <= 1'b0; grad_ovf <= 1'b0; dps <= 0;
               end
         endcase
      end
   end

   // Scoreboard monitor plus check that start never rises while done is still high.
   always @(negedge clk) begin
      if (rst_n && grad_start && !gs_prev)
         checkOutput("gs_rise_while_done", {31'b0, grad_done}, 32'd0);
      gs_prev <= grad_start;
      if (rst_n && done) begin
         if (q.size() == 0) checkOutput("unexpected_done", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            checkOutput("a_out", {16'b0, a_out}, {16'b0, e.a});
            checkOutput("b_out", {16'b0, b_out}, {16'b0, e.b});
            checkOutput("c_out", {16'b0, c_out}, {16'b0, e.c});
            checkOutput("d_out", {16'b0, d_out}, {16'b0, e.d});
            checkOutput("iter_count", {16'b0, iter_count}, {16'b0, e.iter});
            checkOutput("converged", {31'b0, converged}, {31'b0, e.conv});
            checkOutput("sat_flag", {31'b0, sat_flag}, {31'b0, e.sat});
            checkOutput("err_ovf", {31'b0, err_ovf}, {31'b0, e.ovf});
            checkOutput("value_out", value_out, e.value);
         end
      end
   end

   // One full run: push the prediction, start, optionally abort in the first REQ, wait for done.
   task automatic applyStimulus(input logic [63:0] init, input logic [127:0] dif,
                                input bit abrt, input int ovf_it);
      int n;
      @(negedge clk);
      {d_init, c_init, b_init, a_init} = init;
      dif_stim = dif;
      ovf_iter = ovf_it;
      q.push_back(model(init, dif, abrt, ovf_it));
      start = 1'b1;
      if (abrt) begin
         n = 0;
         while (!grad_start && n < 50) begin @(negedge clk); n++; end
         if (!grad_start) checkOutput("abort_wait_timeout", 32'd1, 32'd0);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      n = 0;
      while (!done && n < 300) begin @(negedge clk); n++; end
      if (!done) begin
         checkOutput("done_timeout", 32'd1, 32'd0);
         void'(q.pop_front());
      end
      @(negedge clk);
      checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
      checkOutput("fin_hold_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      checkOutput("no_restart", {31'b0, busy}, 32'd1);
      start = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_fin", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      #12;
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_grad_start", {31'b0, grad_start}, 32'd0);
      checkOutput("rst_a_out", {16'b0, a_out}, 32'd0);
      checkOutput("rst_iter", {16'b0, iter_count}, 32'd0);
      rst_n = 1'b1;
      // basic update with abort after first iteration
      applyStimulus({16'h0, 16'h0, 16'h0, 16'h0500}, {96'h0, 32'h00000100}, 1'b1, 0);
      // saturation both directions
      applyStimulus({16'h0, 16'h0, 16'h7FF0, 16'h8010}, {64'h0, 32'hFFFFFF00, 32'h00000100}, 1'b1, 0);
      // convergence on the first iteration
      applyStimulus({16'h0000, 16'hFF00, 16'h0200, 16'h0100},
                    {32'h1, 32'h1, 32'h1, 32'h1}, 1'b0, 0);
      // iteration limit
      applyStimulus({16'h0000, 16'hF000, 16'h2000, 16'h1000},
                    {32'h100, 32'h100, 32'h100, 32'h100}, 1'b0, 0);
      // overflow on the second handshake
      applyStimulus({16'h0000, 16'hF000, 16'h2000, 16'h1000},
                    {32'h100, 32'h100, 32'h100, 32'h100}, 1'b0, 2);
      // |diff| exactly TOL (negative) converges
      applyStimulus({16'h0, 16'h0, 16'h0, 16'h0010}, {96'h0, 32'hFFFFFFFE}, 1'b0, 0);
      // most negative diff never counts as converged, and saturates
      applyStimulus({16'h0, 16'h0, 16'h0, 16'h0010}, {96'h0, 32'h80000000}, 1'b1, 0);
      // asynchronous reset in the middle of REQ
      @(negedge clk);
      dif_stim = {4{32'h100}};
      ovf_iter = 0;
      start = 1'b1;
      n = 0;
      while (!grad_start && n < 50) begin @(negedge clk); n++; end
      checkOutput("reached_req", {31'b0, grad_start}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_grad_start", {31'b0, grad_start}, 32'd0);
      checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("mid_rst_a_out", {16'b0, a_out}, 32'd0);
      checkOutput("mid_rst_done", {31'b0, done}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // run after reset is clean
      applyStimulus({16'h0, 16'h0, 16'h0, 16'h0500}, {96'h0, 32'h00000100}, 1'b1, 0);
      checkOutput("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
